pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Sits directly beside the system PLL and is clocked from the same 50 MHz reference clock that feeds the PLL.
- Drives the PLL's reset input and consumes its asynchronous locked output.
- Retries the PLL when lock is not acquired within a timeout, and re-resets it on loss of lock.
- Produces a clean, debounced system reset that is released only after lock has been stable for a programmable time.

Parameters:
- RST_PULSE_CYCLES, 16: width of each PLL reset pulse, in refclk cycles (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before releasing reset_out (≥1).
- LOCK_TIMEOUT_CYCLES, 1000000: maximum cycles spent waiting for lock before a retry (≥2).
- CNT_W, 20: width of the shared state counter; must hold max(parameters)-1.

Ports:
- refclk, input, 1: reference clock, 50 MHz; the only clock.
- rst, input, 1: asynchronous, active-high reset of this block.
- locked, input, 1: PLL lock indication, asynchronous to refclk.
- soft_reset, input, 1: refclk-synchronous request to force a PLL re-reset; level-sensitive.
- pll_rst, output, 1: reset to the PLL, active-high.
- reset_out, output, 1: system reset, active-high; direct flop output.
- ready, output, 1: high only in RUN; equals ~reset_out.
- retry_count, output, 8: number of lock timeouts, saturating at 255.
- loss_count, output, 8: number of lock losses while in RUN, saturating at 255.

Behaviour:
- Synchronizer
  - locked passes through a 2-flop synchronizer to give locked_s.
  - Synchronizer flops reset to 0. All decisions use locked_s only.
- Reset values (rst high, asynchronous)
  - state=PLL_RST, cnt=0, pll_rst=1, reset_out=1, ready=0, retry_count=0, loss_count=0.
- Counter
  - cnt clears to 0 on every state change and increments by 1 each cycle while the state is held.
- PLL_RST
  - pll_rst=1.
  - When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK. The pulse is therefore exactly RST_PULSE_CYCLES cycles.
  - locked_s and soft_reset are ignored in this state.
- WAIT_LOCK
  - pll_rst=0.
  - If locked_s=1, go to STABLE.
  - Else if cnt==LOCK_TIMEOUT_CYCLES-1, go to PLL_RST and increment retry_count (saturating).
- STABLE
  - If locked_s=0, return to WAIT_LOCK. The timeout restarts from 0.
  - Else if cnt==LOCK_STABLE_CYCLES-1, go to RUN.
- RUN
  - reset_out=0, ready=1.
  - If locked_s=0, go to PLL_RST and increment loss_count (saturating).
  - Else if soft_reset=1, go to PLL_RST; loss_count is unchanged.
- soft_reset in other states
  - In WAIT_LOCK or STABLE, soft_reset=1 goes to PLL_RST.
  - locked_s loss takes priority over soft_reset.
- Output timing
  - reset_out and pll_rst are registered and change on the same edge as the state transition. No combinational path from any input reaches an output.
  - reset_out=1 in every state except RUN.
- Latency
  - Suppose the locked rising edge is first captured at edge t while in WAIT_LOCK.
  - locked_s goes high after edge t+1, STABLE is entered at edge t+2, and reset_out falls at edge t+2+LOCK_STABLE_CYCLES.
  - Loss of lock in RUN asserts reset_out and pll_rst 3 edges after locked falls (2 synchronizer edges plus 1 transition edge).
- Boundaries
  - Both counters saturate at 255 and never wrap.
  - An asynchronous rst mid-operation immediately restores all reset values, including pll_rst=1, regardless of state.
  - locked glitches shorter than one refclk cycle may or may not be seen; either outcome is legal, but no output may glitch.
- Encoding
  - State encoding is free, but unused encodings must recover to PLL_RST.

Test Plan:
1. Use RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32. Release rst with locked=0 → pll_rst high for exactly 4 edges, then 0; reset_out stays 1.
2. Same parameters. Raise locked 5 cycles after pll_rst falls and hold it → reset_out and ready change exactly 10 edges after locked is first sampled; retry_count=0.
3. Never raise locked → pll_rst re-pulses 4 cycles wide every 36 cycles; retry_count reaches 3 after 3 periods; after 300 timeouts it reads 255.
4. Starting from RUN, drop locked for 3 cycles → reset_out=1 and pll_rst=1 by edge 3; loss_count=1; re-lock with locked held gives RUN again after 4+2+8 cycles.
5. In STABLE, drop locked for 1 cycle at cnt=6 → return to WAIT_LOCK; reset_out is not released until 8 further stable cycles have passed.
6. Pulse soft_reset for 1 cycle in RUN → PLL_RST with a 4-cycle pll_rst pulse and loss_count unchanged; assert rst mid-STABLE → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset sequencer and lock supervisor
//
// Purpose: drives the PLL reset, waits for a synchronized lock, retries on
// lock timeout, re-resets on loss of lock and releases a debounced system
// reset only after lock has held for LOCK_STABLE_CYCLES.
//
// Ports:
//   refclk      in   reference clock, the only clock
//   rst         in   asynchronous active-high reset of this block
//   locked      in   PLL lock indication, asynchronous to refclk
//   soft_reset  in   refclk-synchronous level request to re-reset the PLL
//   pll_rst     out  registered reset to the PLL, active-high
//   reset_out   out  registered system reset, active-high
//   ready       out  high only in RUN (~reset_out)
//   retry_count out  saturating count of lock timeouts
//   loss_count  out  saturating count of lock losses while in RUN
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int CNT_W               = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       reset_out,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic [7:0] loss_count
);

    typedef enum logic [1:0] {
        S_PLL_RST   = 2'd0,
        S_WAIT_LOCK = 2'd1,
        S_STABLE    = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] C_PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sync1;
    logic             r_locked_s;
    logic             r_pll_rst;
    logic             r_reset_out;
    logic [7:0]       r_retry_count;
    logic [7:0]       r_loss_count;
    logic             w_retry_inc;
    logic             w_loss_inc;
    logic             w_pll_rst_nxt;
    logic             w_reset_out_nxt;

    // Two-flop synchronizer; every decision below uses r_locked_s only.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_locked_s <= 1'b0;
        end else begin
            r_sync1    <= locked;
            r_locked_s <= r_sync1;
        end
    end

    // State register together with the registered outputs, so the outputs
    // move on the same edge as the state they describe.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state       <= S_PLL_RST;
            r_cnt         <= '0;
            r_pll_rst     <= 1'b1;
            r_reset_out   <= 1'b1;
            r_retry_count <= 8'd0;
            r_loss_count  <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
            r_pll_rst   <= w_pll_rst_nxt;
            r_reset_out <= w_reset_out_nxt;
            if (w_retry_inc && r_retry_count != 8'hFF) begin
                r_retry_count <= r_retry_count + 8'd1;
            end
            if (w_loss_inc && r_loss_count != 8'hFF) begin
                r_loss_count <= r_loss_count + 8'd1;
            end
        end
    end

    // Next state. In WAIT_LOCK a soft reset outranks a fresh lock; in STABLE
    // and RUN a lock loss outranks a soft reset.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
        w_loss_inc  = 1'b0;
        case (r_state)
            S_PLL_RST: begin
                if (r_cnt == C_PULSE_LAST) begin
                    w_state_nxt = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (soft_reset) begin
                    w_state_nxt = S_PLL_RST;
                end else if (r_locked_s) begin
                    w_state_nxt = S_STABLE;
                end else if (r_cnt == C_TIMEOUT_LAST) begin
                    w_state_nxt = S_PLL_RST;
                    w_retry_inc = 1'b1;
                end
            end
            S_STABLE: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_WAIT_LOCK;
                end else if (soft_reset) begin
                    w_state_nxt = S_PLL_RST;
                end else if (r_cnt == C_STABLE_LAST) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!r_locked_s) begin
                    w_state_nxt = S_PLL_RST;
                    w_loss_inc  = 1'b1;
                end else if (soft_reset) begin
                    w_state_nxt = S_PLL_RST;
                end
            end
            default: w_state_nxt = S_PLL_RST;
        endcase
    end

    // Output values for the state being entered; registered above.
    always_comb begin
        w_pll_rst_nxt   = (w_state_nxt == S_PLL_RST);
        w_reset_out_nxt = (w_state_nxt != S_RUN);
    end

    assign pll_rst     = r_pll_rst;
    assign reset_out   = r_reset_out;
    assign ready       = ~r_reset_out;
    assign retry_count = r_retry_count;
    assign loss_count  = r_loss_count;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - self-checking bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    localparam int RST_PULSE_CYCLES    = 4;
    localparam int LOCK_STABLE_CYCLES  = 8;
    localparam int LOCK_TIMEOUT_CYCLES = 32;
    localparam int PERIOD              = RST_PULSE_CYCLES + LOCK_TIMEOUT_CYCLES;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       soft_reset = 1'b0;
    logic       pll_rst;
    logic       reset_out;
    logic       ready;
    logic [7:0] retry_count;
    logic [7:0] loss_count;

    int n_assert = 0;
    int n_fail   = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RST_PULSE_CYCLES),
        .LOCK_STABLE_CYCLES (LOCK_STABLE_CYCLES),
        .LOCK_TIMEOUT_CYCLES(LOCK_TIMEOUT_CYCLES),
        .CNT_W              (20)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .soft_reset (soft_reset),
        .pll_rst    (pll_rst),
        .reset_out  (reset_out),
        .ready      (ready),
        .retry_count(retry_count),
        .loss_count (loss_count)
    );

    always #10 refclk = ~refclk;

    // Reference model: phase plus the cycle number at which it was entered;
    // timing rules are "phase has lasted N cycles". lk_hist holds the raw
    // locked samples, the decision value being the one from two edges back.
    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_RUN  = 3;

    int m_phase, m_entry, m_cyc, m_retry, m_loss;
    bit lk_hist[$];

    task automatic model_reset();
        m_phase = P_RST;
        m_entry = 0;
        m_cyc   = 0;
        m_retry = 0;
        m_loss  = 0;
        lk_hist = '{1'b0, 1'b0};
    endtask

    task automatic model_edge(input bit lk, input bit sr);
        bit ls;
        int dur;
        int nxt;
        ls  = lk_hist[0];
        dur = m_cyc - m_entry + 1;
        nxt = m_phase;
        if (m_phase == P_RST) begin
            if (dur == RST_PULSE_CYCLES) nxt = P_WAIT;
        end else if (m_phase == P_WAIT) begin
            if (sr) nxt = P_RST;
            else if (ls) nxt = P_STAB;
            else if (dur == LOCK_TIMEOUT_CYCLES) begin
                nxt = P_RST;
                m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            end
        end else if (m_phase == P_STAB) begin
            if (!ls) nxt = P_WAIT;
            else if (sr) nxt = P_RST;
            else if (dur == LOCK_STABLE_CYCLES) nxt = P_RUN;
        end else begin
            if (!ls) begin
                nxt = P_RST;
                m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            end else if (sr) nxt = P_RST;
        end
        if (nxt != m_phase) begin
            m_phase = nxt;
            m_entry = m_cyc + 1;
        end
        m_cyc++;
        void'(lk_hist.pop_front());
        lk_hist.push_back(lk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pll_rst"},   32'(pll_rst),     32'(m_phase == P_RST));
        check({tag, ".reset_out"}, 32'(reset_out),   32'(m_phase != P_RUN));
        check({tag, ".ready"},     32'(ready),       32'(m_phase == P_RUN));
        check({tag, ".retry"},     32'(retry_count), 32'(m_retry));
        check({tag, ".loss"},      32'(loss_count),  32'(m_loss));
    endtask

    // One refclk cycle: model follows the edge, DUT checked at the falling edge.
    task automatic step(input string tag);
        @(posedge refclk);
        if (rst) model_reset();
        else model_edge(locked, soft_reset);
        @(negedge refclk);
        check_all(tag);
    endtask

    task automatic steps_until_ready(input string tag, input int bound, output int n);
        n = 0;
        while (ready !== 1'b1 && n <= bound) begin
            step(tag);
            n++;
        end
    endtask

    int n;
    int hold;

    initial begin
        model_reset();
        // Reset state while rst is held
        repeat (3) step("reset");

        // 1: pll_rst pulse is exactly RST_PULSE_CYCLES edges
        rst = 1'b0;
        #1 check("t1.pll_rst_at_release", 32'(pll_rst), 32'd1);
        repeat (RST_PULSE_CYCLES - 1) step("t1");
        check("t1.pll_rst_before_last", 32'(pll_rst), 32'd1);
        step("t1");
        check("t1.pll_rst_after_pulse", 32'(pll_rst), 32'd0);
        check("t1.reset_out", 32'(reset_out), 32'd1);

        // 2: lock acquisition latency = 2 + LOCK_STABLE_CYCLES edges after capture
        repeat (5) step("t2.wait");
        locked = 1'b1;
        steps_until_ready("t2", 100, n);
        check("t2.ready_latency_steps", 32'(n), 32'(1 + 2 + LOCK_STABLE_CYCLES));
        check("t2.retry_count", 32'(retry_count), 32'd0);

        // 4: loss of lock in RUN
        locked = 1'b0;
        step("t4");
        step("t4");
        check("t4.reset_out_edge2", 32'(reset_out), 32'd0);
        step("t4");
        check("t4.reset_out_edge3", 32'(reset_out), 32'd1);
        check("t4.pll_rst_edge3", 32'(pll_rst), 32'd1);
        check("t4.loss_count", 32'(loss_count), 32'd1);
        locked = 1'b1;
        steps_until_ready("t4.relock", 100, n);
        check("t4.relock_ready", 32'(ready), 32'd1);

        // 6a: soft reset pulse in RUN gives a full pulse, loss unchanged
        soft_reset = 1'b1;
        step("t6");
        soft_reset = 1'b0;
        n = 1;
        while (pll_rst === 1'b1 && n < 20) begin
            step("t6");
            n++;
        end
        check("t6.soft_pulse_width", 32'(n - 1), 32'(RST_PULSE_CYCLES));
        check("t6.loss_unchanged", 32'(loss_count), 32'd1);

        // 5: locked_s drops while STABLE count is 6 -> back to WAIT_LOCK
        n = 0;
        while (!(m_phase == P_STAB && m_cyc - m_entry == 4) && n < 100) begin
            step("t5.seek");
            n++;
        end
        check("t5.reached_stable", 32'(m_phase), 32'(P_STAB));
        locked = 1'b0;
        step("t5");
        locked = 1'b1;
        step("t5");
        step("t5");
        check("t5.not_released", 32'(reset_out), 32'd1);
        steps_until_ready("t5.relock", 100, n);
        check("t5.ready_after_return", 32'(n), 32'(1 + LOCK_STABLE_CYCLES));

        // Randomized locked / soft_reset activity against the model
        for (int seg = 0; seg < 150; seg++) begin
            locked = ($urandom_range(0, 3) != 0);
            hold   = $urandom_range(1, 40);
            for (int k = 0; k < hold; k++) begin
                soft_reset = ($urandom_range(0, 19) == 0);
                step("rand");
            end
        end
        soft_reset = 1'b0;

        // 6b: async rst mid-STABLE restores reset values immediately
        locked = 1'b1;
        n = 0;
        while (!(m_phase == P_STAB && m_cyc - m_entry == 3) && n < 200) begin
            step("t6b.seek");
            n++;
        end
        check("t6b.reached_stable", 32'(m_phase), 32'(P_STAB));
        #3 rst = 1'b1;
        #1;
        check("t6b.pll_rst", 32'(pll_rst), 32'd1);
        check("t6b.reset_out", 32'(reset_out), 32'd1);
        check("t6b.ready", 32'(ready), 32'd0);
        check("t6b.retry", 32'(retry_count), 32'd0);
        check("t6b.loss", 32'(loss_count), 32'd0);
        model_reset();
        step("t6b.hold");

        // 3: no lock ever -> periodic retries, saturating count
        locked = 1'b0;
        rst = 1'b0;
        repeat (3 * PERIOD - 1) step("t3");
        check("t3.retry_before_3rd", 32'(retry_count), 32'd2);
        step("t3");
        check("t3.retry_after_3", 32'(retry_count), 32'd3);
        check("t3.pll_rst_repulse", 32'(pll_rst), 32'd1);
        repeat (297 * PERIOD) step("t3.sat");
        check("t3.retry_saturated", 32'(retry_count), 32'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
